// File: rtl/router_rx_controller.sv
// Receive-side packet controller: decapsulates the header at the head of the
// receive FIFO, then streams the payload into local memory or drains it.
module router_rx_controller #(
  parameter int unsigned AURORA_DATA_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH             = 10,
  parameter int unsigned NUMBER_PACKET          = 19,
  parameter int unsigned RECOGNIZE_ROUTER_WIDTH = 2,
  parameter logic [RECOGNIZE_ROUTER_WIDTH-1:0] LOCAL_ROUTER_ID = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_empty,
  input  logic [AURORA_DATA_WIDTH-1:0] rx_data,
  output logic                         rx_rd_en,
  output logic                         start_decap_pkt,
  input  logic                         decap_done,
  input  logic [8:0]                   header_pkt_recv,
  input  logic [ADDR_WIDTH-1:0]        dst_addr_arbiter_recv,
  output logic                         arbiter_write_req,
  input  logic                         arbiter_write_gnt,
  output logic [ADDR_WIDTH-1:0]        arbiter_dst_addr,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [AURORA_DATA_WIDTH-1:0] mem_wdata,
  output logic [1:0]                   rx_src_router,
  output logic                         rx_done,
  output logic                         rx_drop,
  output logic [15:0]                  rx_pkt_cnt,
  output logic [15:0]                  rx_drop_cnt
);

  localparam int unsigned   CNT_W     = $clog2(NUMBER_PACKET + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUMBER_PACKET - 1);
  localparam logic [15:0]   CNT_MAX   = 16'hFFFF;

  typedef enum logic [3:0] {
    IDLE,
    START_DECAP,
    WAIT_DECAP,
    POP_HDR,
    WRITE_REQ,
    WRITE_DATA,
    DRAIN,
    DONE_OK,
    DONE_DROP
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       hdr_ttl;
  logic [1:0]       hdr_dst;
  logic [1:0]       hdr_src;
  logic             accept_c;
  logic             cnt_inc_c;
  logic             unused_hdr_rsvd;

  assign unused_hdr_rsvd = ^header_pkt_recv[2:0];

  assign accept_c = (hdr_ttl != 2'd0) &&
                    (RECOGNIZE_ROUTER_WIDTH'(hdr_dst) == LOCAL_ROUTER_ID);

  // Address and data are forced to zero outside an actual write cycle.
  assign mem_addr  = mem_we ? (arbiter_dst_addr + ADDR_WIDTH'(cnt)) : '0;
  assign mem_wdata = mem_we ? rx_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n           = state;
    rx_rd_en          = 1'b0;
    mem_we            = 1'b0;
    start_decap_pkt   = 1'b0;
    arbiter_write_req = 1'b0;
    rx_done           = 1'b0;
    rx_drop           = 1'b0;
    cnt_inc_c         = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_empty) state_n = START_DECAP;
      end
      START_DECAP: begin
        start_decap_pkt = 1'b1;
        state_n         = WAIT_DECAP;
      end
      WAIT_DECAP: begin
        if (decap_done) state_n = POP_HDR;
      end
      POP_HDR: begin
        rx_rd_en = 1'b1;
        state_n  = accept_c ? WRITE_REQ : DRAIN;
      end
      WRITE_REQ: begin
        arbiter_write_req = 1'b1;
        if (arbiter_write_gnt) state_n = WRITE_DATA;
      end
      WRITE_DATA: begin
        arbiter_write_req = 1'b1;
        if (!rx_empty && arbiter_write_gnt) begin
          mem_we    = 1'b1;
          rx_rd_en  = 1'b1;
          cnt_inc_c = 1'b1;
          if (cnt == LAST_WORD) state_n = DONE_OK;
        end
      end
      DRAIN: begin
        if (!rx_empty) begin
          rx_rd_en  = 1'b1;
          cnt_inc_c = 1'b1;
          if (cnt == LAST_WORD) state_n = DONE_DROP;
        end
      end
      DONE_OK: begin
        rx_done = 1'b1;
        state_n = IDLE;
      end
      DONE_DROP: begin
        rx_drop = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Header latch, word counter and saturating packet statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt              <= '0;
      hdr_ttl          <= '0;
      hdr_dst          <= '0;
      hdr_src          <= '0;
      arbiter_dst_addr <= '0;
      rx_src_router    <= '0;
      rx_pkt_cnt       <= '0;
      rx_drop_cnt      <= '0;
    end else begin
      if (state == WAIT_DECAP && decap_done) begin
        hdr_ttl          <= header_pkt_recv[8:7];
        hdr_dst          <= header_pkt_recv[6:5];
        hdr_src          <= header_pkt_recv[4:3];
        arbiter_dst_addr <= dst_addr_arbiter_recv;
      end
      if (state == POP_HDR) begin
        cnt <= '0;
        if (accept_c) rx_src_router <= hdr_src;
      end else if (cnt_inc_c) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == DONE_OK && rx_pkt_cnt != CNT_MAX)
        rx_pkt_cnt <= rx_pkt_cnt + 16'd1;
      if (state == DONE_DROP && rx_drop_cnt != CNT_MAX)
        rx_drop_cnt <= rx_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_router_rx_controller.sv
// Bench for router_rx_controller: FIFO/decap/arbiter models around the DUT,
// a packet table for the plain cases and hand-written multi-cycle sequences.
module tb_router_rx_controller;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int NP = 19;

  typedef struct packed {
    logic [8:0]    hdr;
    logic [AW-1:0] addr;
  } hdr_rec_t;

  typedef struct {
    logic [8:0]    hdr;
    logic [AW-1:0] base;
    int            exp_writes;
    int            exp_done;
    int            exp_drop;
    logic [1:0]    exp_src;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_empty = 1'b1;
  logic [DW-1:0] rx_data = '0;
  logic          decap_done = 1'b0;
  logic [8:0]    header_pkt_recv = '0;
  logic [AW-1:0] dst_addr_arbiter_recv = '0;
  logic          arbiter_write_gnt = 1'b0;

  logic          rx_rd_en;
  logic          start_decap_pkt;
  logic          arbiter_write_req;
  logic [AW-1:0] arbiter_dst_addr;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    rx_src_router;
  logic          rx_done;
  logic          rx_drop;
  logic [15:0]   rx_pkt_cnt;
  logic [15:0]   rx_drop_cnt;

  router_rx_controller #(
    .AURORA_DATA_WIDTH     (DW),
    .ADDR_WIDTH            (AW),
    .NUMBER_PACKET         (NP),
    .RECOGNIZE_ROUTER_WIDTH(2),
    .LOCAL_ROUTER_ID       (2'b00)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rx_empty             (rx_empty),
    .rx_data              (rx_data),
    .rx_rd_en             (rx_rd_en),
    .start_decap_pkt      (start_decap_pkt),
    .decap_done           (decap_done),
    .header_pkt_recv      (header_pkt_recv),
    .dst_addr_arbiter_recv(dst_addr_arbiter_recv),
    .arbiter_write_req    (arbiter_write_req),
    .arbiter_write_gnt    (arbiter_write_gnt),
    .arbiter_dst_addr     (arbiter_dst_addr),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .rx_src_router        (rx_src_router),
    .rx_done              (rx_done),
    .rx_drop              (rx_drop),
    .rx_pkt_cnt           (rx_pkt_cnt),
    .rx_drop_cnt          (rx_drop_cnt)
  );

  always #5 clk = ~clk;

  // Written only by the main sequence.
  logic [DW-1:0] stage_q [$];
  hdr_rec_t      hdr_stage [$];
  int            flush_req = 0;
  int            spur_req = 0;
  int            gnt_delay = 0;
  int            gap_word = -1;
  int            gap_len = 0;
  int            emp_word = -1;
  int            emp_len = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  // Written only by the model/monitor process.
  logic [DW-1:0] fifo [$];
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  int            start_cyc_q [$];
  int            done_cyc_q [$];
  logic [DW-1:0] unused_pop;
  int stage_idx = 0, hdr_idx = 0, flush_seen = 0, spur_seen = 0;
  int cyc = 0, push_cyc = 0;
  int pop_n = 0, start_n = 0, done_n = 0, drop_n = 0, req_n = 0, viol_n = 0;
  int wr_pkt = 0, req_age = 0, gap_left = 0, emp_left = 0;
  bit gap_fired = 1'b0, emp_fired = 1'b0, stall = 1'b0, pop_s = 1'b0, start_s = 1'b0;

  function automatic logic [8:0] mk_hdr(input logic [1:0] ttl, input logic [1:0] dst,
                                        input logic [1:0] src);
    return {ttl, dst, src, 3'b000};
  endfunction

  function automatic logic [DW-1:0] payload(input int p, input int j);
    return {16'hCAFE, 16'(p), 32'(j)};
  endfunction

  // Sample on the falling edge, apply FIFO/decap/grant effects just after the rising edge.
  always begin
    @(negedge clk);
    pop_s   = 1'b0;
    start_s = 1'b0;
    if (rst_n) begin
      if (rx_rd_en && !rx_empty) begin pop_s = 1'b1; pop_n++; end
      if (rx_rd_en && rx_empty) viol_n++;
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
        wr_pkt++;
        if (rx_empty || !arbiter_write_gnt || !rx_rd_en) viol_n++;
      end
      if (start_decap_pkt) begin
        start_s = 1'b1;
        start_n++;
        start_cyc_q.push_back(cyc);
        wr_pkt    = 0;
        gap_fired = 1'b0;
        emp_fired = 1'b0;
      end
      if (rx_done) begin done_n++; done_cyc_q.push_back(cyc); end
      if (rx_drop) drop_n++;
      if (arbiter_write_req) req_n++;
    end
    if (rst_n && arbiter_write_req) req_age++;
    else                            req_age = 0;

    @(posedge clk);
    #1;
    cyc++;
    if (flush_req != flush_seen) begin
      fifo.delete();
      stage_idx  = stage_q.size();
      hdr_idx    = hdr_stage.size();
      flush_seen = flush_req;
    end
    if (pop_s && fifo.size() > 0) unused_pop = fifo.pop_front();
    if (stage_idx < stage_q.size()) begin
      push_cyc = cyc;
      while (stage_idx < stage_q.size()) begin
        fifo.push_back(stage_q[stage_idx]);
        stage_idx++;
      end
    end
    if (start_s && hdr_idx < hdr_stage.size()) begin
      decap_done            = 1'b1;
      header_pkt_recv       = hdr_stage[hdr_idx].hdr;
      dst_addr_arbiter_recv = hdr_stage[hdr_idx].addr;
      hdr_idx++;
    end else if (spur_req != spur_seen) begin
      spur_seen             = spur_req;
      decap_done            = 1'b1;
      header_pkt_recv       = mk_hdr(2'd3, 2'd0, 2'd1);
      dst_addr_arbiter_recv = 10'h155;
    end else begin
      decap_done = 1'b0;
    end
    if (!gap_fired && gap_word >= 0 && wr_pkt == gap_word) begin
      gap_left = gap_len; gap_fired = 1'b1;
    end
    if (!emp_fired && emp_word >= 0 && wr_pkt == emp_word) begin
      emp_left = emp_len; emp_fired = 1'b1;
    end
    if (gap_left > 0) begin
      arbiter_write_gnt = 1'b0;
      gap_left--;
    end else begin
      arbiter_write_gnt = (gnt_delay == 0) || (req_age >= gnt_delay);
    end
    if (emp_left > 0) begin stall = 1'b1; emp_left--; end
    else                      stall = 1'b0;
    rx_empty = (fifo.size() == 0) || stall;
    rx_data  = (fifo.size() > 0) ? fifo[0] : '0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push_packet(input int p, input logic [8:0] hdr, input logic [AW-1:0] base);
    hdr_rec_t r;
    r.hdr  = hdr;
    r.addr = base;
    hdr_stage.push_back(r);
    stage_q.push_back({16'hBEEF, 16'(p), 32'hFFFF_FFFF});
    for (int j = 0; j < NP; j++) stage_q.push_back(payload(p, j));
  endtask

  task automatic wait_pkts(input string nm, input int tgt);
    int t = 0;
    while ((done_n + drop_n) < tgt && t < 600) begin
      @(posedge clk);
      t++;
    end
    chk({nm, "_finished"}, 64'((done_n + drop_n) >= tgt), 64'd1);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic check_writes(input string nm, input int first, input int p,
                              input logic [AW-1:0] base);
    int bad_a = 0;
    int bad_d = 0;
    for (int j = 0; j < NP; j++) begin
      if (first + j >= wr_addr_q.size()) begin
        bad_a++;
        bad_d++;
      end else begin
        if (wr_addr_q[first+j] !== AW'(base + AW'(j))) bad_a++;
        if (wr_data_q[first+j] !== payload(p, j))      bad_d++;
      end
    end
    chk({nm, "_addr_errors"}, 64'(bad_a), 64'd0);
    chk({nm, "_data_errors"}, 64'(bad_d), 64'd0);
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_ctrl"}, 64'({rx_rd_en, start_decap_pkt, arbiter_write_req, mem_we,
                            rx_done, rx_drop}), 64'd0);
    chk({nm, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({nm, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({nm, "_dst_addr"}, 64'(arbiter_dst_addr), 64'd0);
    chk({nm, "_src"}, 64'(rx_src_router), 64'd0);
    chk({nm, "_pkt_cnt"}, 64'(rx_pkt_cnt), 64'd0);
    chk({nm, "_drop_cnt"}, 64'(rx_drop_cnt), 64'd0);
  endtask

  vec_t vec [4];
  int exp_pkt = 0, exp_drp = 0;
  int s_pop, s_wr, s_req, s_viol, s_done, s_drop, s_start, s_dcyc, lat;

  task automatic snapshot();
    s_pop   = pop_n;
    s_wr    = wr_addr_q.size();
    s_req   = req_n;
    s_viol  = viol_n;
    s_done  = done_n;
    s_drop  = drop_n;
    s_start = start_n;
    s_dcyc  = done_cyc_q.size();
  endtask

  initial begin
    vec[0] = '{mk_hdr(2'd3, 2'd0, 2'd2), 10'h100, NP, 1, 0, 2'd2};
    vec[1] = '{mk_hdr(2'd1, 2'd0, 2'd1), 10'h3F8, NP, 1, 0, 2'd1};
    vec[2] = '{mk_hdr(2'd0, 2'd0, 2'd3), 10'h050, 0,  0, 1, 2'd1};
    vec[3] = '{mk_hdr(2'd2, 2'd1, 2'd0), 10'h060, 0,  0, 1, 2'd1};

    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    for (int i = 0; i < 4; i++) begin
      snapshot();
      push_packet(i, vec[i].hdr, vec[i].base);
      wait_pkts($sformatf("v%0d", i), s_done + s_drop + 1);
      exp_pkt += vec[i].exp_done;
      exp_drp += vec[i].exp_drop;
      lat = (start_cyc_q.size() > s_start) ? start_cyc_q[s_start] - push_cyc : -1;
      chk($sformatf("v%0d_start_latency", i), 64'(lat), 64'd1);
      chk($sformatf("v%0d_writes", i), 64'(wr_addr_q.size() - s_wr), 64'(vec[i].exp_writes));
      chk($sformatf("v%0d_pops", i), 64'(pop_n - s_pop), 64'(NP + 1));
      chk($sformatf("v%0d_done_pulses", i), 64'(done_n - s_done), 64'(vec[i].exp_done));
      chk($sformatf("v%0d_drop_pulses", i), 64'(drop_n - s_drop), 64'(vec[i].exp_drop));
      chk($sformatf("v%0d_req_seen", i), 64'((req_n - s_req) > 0), 64'(vec[i].exp_writes > 0));
      chk($sformatf("v%0d_violations", i), 64'(viol_n - s_viol), 64'd0);
      chk($sformatf("v%0d_src", i), 64'(rx_src_router), 64'(vec[i].exp_src));
      chk($sformatf("v%0d_pkt_cnt", i), 64'(rx_pkt_cnt), 64'(exp_pkt));
      chk($sformatf("v%0d_drop_cnt", i), 64'(rx_drop_cnt), 64'(exp_drp));
      if (vec[i].exp_writes > 0) check_writes($sformatf("v%0d", i), s_wr, i, vec[i].base);
    end

    // Late grant, grant gap at word 7, FIFO underrun at word 12.
    snapshot();
    gnt_delay = 5; gap_word = 7; gap_len = 3; emp_word = 12; emp_len = 4;
    push_packet(10, mk_hdr(2'd3, 2'd0, 2'd3), 10'h2A0);
    wait_pkts("stall", s_done + s_drop + 1);
    gnt_delay = 0; gap_word = -1; emp_word = -1;
    exp_pkt++;
    chk("stall_writes", 64'(wr_addr_q.size() - s_wr), 64'(NP));
    chk("stall_pops", 64'(pop_n - s_pop), 64'(NP + 1));
    chk("stall_violations", 64'(viol_n - s_viol), 64'd0);
    chk("stall_done_pulses", 64'(done_n - s_done), 64'd1);
    chk("stall_pkt_cnt", 64'(rx_pkt_cnt), 64'(exp_pkt));
    chk("stall_src", 64'(rx_src_router), 64'd3);
    check_writes("stall", s_wr, 10, 10'h2A0);

    // decap_done while idle must be ignored.
    snapshot();
    spur_req++;
    repeat (4) @(posedge clk);
    #2;
    chk("spur_starts", 64'(start_n - s_start), 64'd0);
    chk("spur_pops", 64'(pop_n - s_pop), 64'd0);
    chk("spur_dst_addr", 64'(arbiter_dst_addr), 64'h2A0);

    // Two packets queued together.
    snapshot();
    push_packet(11, mk_hdr(2'd1, 2'd0, 2'd1), 10'h010);
    push_packet(12, mk_hdr(2'd2, 2'd0, 2'd2), 10'h380);
    wait_pkts("b2b", s_done + s_drop + 2);
    exp_pkt += 2;
    lat = (start_cyc_q.size() > s_start + 1 && done_cyc_q.size() > s_dcyc)
          ? start_cyc_q[s_start+1] - done_cyc_q[s_dcyc] : -1;
    chk("b2b_done_to_start", 64'(lat), 64'd2);
    chk("b2b_writes", 64'(wr_addr_q.size() - s_wr), 64'(2 * NP));
    chk("b2b_pkt_cnt", 64'(rx_pkt_cnt), 64'(exp_pkt));
    chk("b2b_src", 64'(rx_src_router), 64'd2);
    check_writes("b2b_first", s_wr, 11, 10'h010);
    check_writes("b2b_second", s_wr + NP, 12, 10'h380);

    // Reset in the middle of the payload.
    snapshot();
    push_packet(13, mk_hdr(2'd1, 2'd0, 2'd2), 10'h200);
    begin
      int t = 0;
      while (!(start_n > s_start && wr_pkt >= 10) && t < 600) begin
        @(posedge clk);
        t++;
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    chk("midrst_partial", 64'((wr_addr_q.size() - s_wr) >= 10 && (wr_addr_q.size() - s_wr) < NP),
        64'd1);
    flush_req++;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("midrst_no_done", 64'(done_n - s_done), 64'd0);

    snapshot();
    push_packet(14, mk_hdr(2'd1, 2'd0, 2'd3), 10'h040);
    wait_pkts("fresh", s_done + s_drop + 1);
    chk("fresh_writes", 64'(wr_addr_q.size() - s_wr), 64'(NP));
    chk("fresh_pops", 64'(pop_n - s_pop), 64'(NP + 1));
    chk("fresh_done_pulses", 64'(done_n - s_done), 64'd1);
    chk("fresh_pkt_cnt", 64'(rx_pkt_cnt), 64'd1);
    chk("fresh_drop_cnt", 64'(rx_drop_cnt), 64'd0);
    chk("fresh_src", 64'(rx_src_router), 64'd3);
    check_writes("fresh", s_wr, 14, 10'h040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
